falling_edge_event_arbiter: RTL
===============================

Name: falling_edge_event_arbiter

Overview:
- Multi-channel front end for falling-edge events: synchronises N_CH asynchronous input lines, detects each high-to-low transition and latches it as a pending event.
- Pending events are served round-robin to a single consumer over a valid/ready handshake.
- Sits between raw board inputs (buttons, sensor strobes) and a control FSM that needs one event at a time with a channel ID.

Parameters:
- N_CH, 4, number of input channels (2..16).
- ID_W, 2, width of evt_id; must equal clog2(N_CH).
- SYNC_STAGES, 2, synchroniser depth per channel (>=2).

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst  input  1  asynchronous active-low reset
- in  input  N_CH  raw asynchronous lines, idle high
- ch_enable  input  N_CH  per-channel event enable
- evt_ready  input  1  consumer accepts offered event
- clr_overflow  input  1  one-cycle pulse, clears all overflow flags
- evt_valid  output  1  event offered
- evt_id  output  ID_W  channel of offered event
- overflow  output  N_CH  sticky per-channel lost-event flag
- busy  output  1  high while any pending bit is set or evt_valid is high

Behaviour:
- Reset (rst=0, async): sync flops and prev flops = 1 (no spurious edge after release); pending=0; overflow=0; evt_valid=0; evt_id=0; last_grant=N_CH-1 (channel 0 has first priority); state=IDLE.
- Edge detect per channel: edge[i] = prev[i] & ~sync[i], where sync[i] is the last sync stage and prev[i] is sync[i] delayed one cycle. One pulse per high-to-low transition. No retrigger while the line stays low. Rising edges are ignored.
- Latency: pin low first sampled at edge k -> pending set at edge k+SYNC_STAGES -> evt_valid high after edge k+SYNC_STAGES+1 (IDLE, nothing else pending).
- Pending update per cycle, in priority order:
  - Cleared when selected by the arbiter.
  - Set if edge[i] & ch_enable[i].
  - Cleared if ch_enable[i]=0.
- Overflow: if edge[i] & ch_enable[i] & pending[i] and pending[i] is not being selected that cycle, set overflow[i]. An edge on the channel currently offered is not an overflow; it just sets pending again. clr_overflow clears all flags; a set in the same cycle wins.
- FSM states: IDLE, OFFER.
  - IDLE: if any pending, select the first set bit searching from last_grant+1 upward with wrap. Register evt_id, set evt_valid, clear that pending bit, go to OFFER. Otherwise stay.
  - OFFER: evt_valid and evt_id held stable until evt_ready=1. On the handshake, last_grant=evt_id. If any pending bit is set that cycle (registered value), select the next one immediately (back-to-back, evt_valid stays 1). Else evt_valid=0 and go to IDLE.
- Disabling a channel while its event is offered does not withdraw the offer; it completes normally.
- evt_ready while evt_valid=0 is ignored.
- Reset mid-offer: evt_valid drops asynchronously and the event is lost. No overflow is recorded.
- busy = |pending | evt_valid, combinational.

Decomposition:
- Package falling_edge_pkg: state encoding localparams (ST_IDLE=1'b0, ST_OFFER=1'b1) and default parameter values.
- Sub-module falling_edge_sync: one channel's synchroniser, prev flop and edge pulse. Instantiated N_CH times via generate.
- Round-robin selection is a function inside the top module.

Test Plan:
- Reset release with all in=1, then hold 20 cycles -> evt_valid=0, overflow=0, busy=0, no spurious events.
- in[2] falls at edge k, evt_ready=1, all enabled -> evt_valid high after edge k+3 for exactly 1 cycle with evt_id=2, then IDLE.
- in[0], in[1], in[3] fall in the same cycle, evt_ready=1 -> three back-to-back events with IDs 0,1,3. A second burst then yields order 0,1,3 starting after last_grant=3.
- evt_ready=0 while in[1] falls twice (line returns high between falls) -> first event offered and held, second sets pending. A third fall sets overflow[1]=1. After evt_ready: IDs 1,1 delivered. clr_overflow pulse -> overflow=0.
- ch_enable[3]=0 and in[3] falls -> no event, busy=0. With ch_enable[3]=1, fall, then ch_enable[3]=0 before grant while channel 1 is offered -> pending[3] cleared, no ID 3 delivered.
- Assert rst=0 mid-OFFER with evt_id=2 -> evt_valid=0 immediately. After release, no event is delivered until a new falling edge.

Source files
------------

// File: rtl/falling_edge_pkg.sv
// Shared types and default sizing for the falling-edge event arbiter.
package falling_edge_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_OFFER = 1'b1
    } state_e;

    localparam int DEF_N_CH        = 4;
    localparam int DEF_ID_W        = 2;
    localparam int DEF_SYNC_STAGES = 2;

endpackage

// File: rtl/falling_edge_sync.sv
// One channel: multi-flop synchroniser, previous-value flop and high-to-low pulse.
module falling_edge_sync
    import falling_edge_pkg::*;
#(
    parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
    input  logic clk,
    input  logic rst,
    input  logic line_i,
    output logic fall_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    // Flops come out of reset high so an idle-high line never fakes an edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q <= '1;
            prev_q <= 1'b1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], line_i};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign fall_o = prev_q & ~sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/falling_edge_event_arbiter.sv
// Latches falling edges on N_CH async lines and serves them round-robin over valid/ready.
module falling_edge_event_arbiter
    import falling_edge_pkg::*;
#(
    parameter int N_CH        = DEF_N_CH,
    parameter int ID_W        = DEF_ID_W,
    parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N_CH-1:0] in,
    input  logic [N_CH-1:0] ch_enable,
    input  logic            evt_ready,
    input  logic            clr_overflow,
    output logic            evt_valid,
    output logic [ID_W-1:0] evt_id,
    output logic [N_CH-1:0] overflow,
    output logic            busy
);

    state_e          state_q, state_d;
    logic [N_CH-1:0] pending_q, pending_d;
    logic [N_CH-1:0] overflow_q, overflow_d;
    logic            evt_valid_q, evt_valid_d;
    logic [ID_W-1:0] evt_id_q, evt_id_d;
    logic [ID_W-1:0] last_grant_q, last_grant_d;

    logic [N_CH-1:0] fall;
    logic [N_CH-1:0] edge_en;
    logic [N_CH-1:0] sel_vec;
    logic [ID_W-1:0] rr_base;
    logic [ID_W-1:0] grant_id;
    logic            grant;

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        falling_edge_sync #(
            .SYNC_STAGES(SYNC_STAGES)
        ) u_sync (
            .clk   (clk),
            .rst   (rst),
            .line_i(in[g]),
            .fall_o(fall[g])
        );
    end

    // First requesting channel strictly after 'last', wrapping around.
    function automatic logic [ID_W-1:0] rr_pick(input logic [N_CH-1:0] req,
                                                input logic [ID_W-1:0] last);
        logic [ID_W-1:0] sel;
        logic            found;
        int              idx;
        sel   = '0;
        found = 1'b0;
        for (int off = 1; off <= N_CH; off++) begin
            idx = (int'(last) + off) % N_CH;
            if (!found && req[idx]) begin
                sel   = ID_W'(idx);
                found = 1'b1;
            end
        end
        return sel;
    endfunction

    assign edge_en  = fall & ch_enable;
    assign rr_base  = (state_q == ST_OFFER) ? evt_id_q : last_grant_q;
    assign grant_id = rr_pick(pending_q, rr_base);

    always_comb begin
        state_d      = state_q;
        evt_valid_d  = evt_valid_q;
        evt_id_d     = evt_id_q;
        last_grant_d = last_grant_q;
        grant        = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (|pending_q) begin
                    grant       = 1'b1;
                    evt_id_d    = grant_id;
                    evt_valid_d = 1'b1;
                    state_d     = ST_OFFER;
                end
            end
            ST_OFFER: begin
                if (evt_ready) begin
                    last_grant_d = evt_id_q;
                    if (|pending_q) begin
                        grant    = 1'b1;
                        evt_id_d = grant_id;
                    end else begin
                        evt_valid_d = 1'b0;
                        state_d     = ST_IDLE;
                    end
                end
            end
            default: begin
                state_d     = ST_IDLE;
                evt_valid_d = 1'b0;
            end
        endcase
    end

    // A fresh edge on the channel being granted re-arms it instead of counting as lost.
    always_comb begin
        sel_vec    = grant ? (N_CH'(1) << grant_id) : '0;
        pending_d  = pending_q & ~sel_vec;
        pending_d  = pending_d | edge_en;
        pending_d  = pending_d & ch_enable;
        overflow_d = clr_overflow ? '0 : overflow_q;
        overflow_d = overflow_d | (edge_en & pending_q & ~sel_vec);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            pending_q    <= '0;
            overflow_q   <= '0;
            evt_valid_q  <= 1'b0;
            evt_id_q     <= '0;
            last_grant_q <= ID_W'(N_CH - 1);
        end else begin
            state_q      <= state_d;
            pending_q    <= pending_d;
            overflow_q   <= overflow_d;
            evt_valid_q  <= evt_valid_d;
            evt_id_q     <= evt_id_d;
            last_grant_q <= last_grant_d;
        end
    end

    assign evt_valid = evt_valid_q;
    assign evt_id    = evt_id_q;
    assign overflow  = overflow_q;
    assign busy      = (|pending_q) | evt_valid_q;

endmodule
